// File: rtl/wb_copy_pkg.sv
// Shared types and default sizing for the Wishbone block-copy initiator.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package wb_copy_pkg;

   localparam int WB_COPY_AW      = 11;
   localparam int WB_COPY_DW      = 32;
   localparam int WB_COPY_LW      = 12;
   localparam int WB_COPY_TIMEOUT = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      DONE    = 3'd5
   } state_e;

endpackage

// File: rtl/wb_copy_master.sv
// Wishbone pipelined initiator copying len words from src to dst, one read then one write per word; optional ack watchdog via WB_COPY_TIMEOUT_EN.
// Latency: 4 cycles per word with zero-stall 1-cycle-ack slave; done_o in the cycle 4N+1 edges after start is sampled (1 for len=0).
// Backpressure: holds addr/we/data while stall is high, never more than one access outstanding; cyc stays high for the whole copy.
module wb_copy_master
   import wb_copy_pkg::*;
#(
   parameter int AW             = WB_COPY_AW,
   parameter int DW             = WB_COPY_DW,
   parameter int LW             = WB_COPY_LW,
   parameter int TIMEOUT_CYCLES = WB_COPY_TIMEOUT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [AW-1:0]   src_i,
   input  logic [AW-1:0]   dst_i,
   input  logic [LW-1:0]   len_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_addr_o,
   output logic [DW-1:0]   wb_data_o,
   output logic [DW/8-1:0] wb_sel_o,
   input  logic            wb_ack_i,
   input  logic            wb_stall_i,
   input  logic [DW-1:0]   wb_data_i
);

   state_e        r_state;
   logic [AW-1:0] r_src;
   logic [AW-1:0] r_dst;
   logic [AW-1:0] r_addr;
   logic [LW-1:0] r_rem;
   logic [DW-1:0] r_wdat;
   logic          r_cyc;
   logic          r_stb;
   logic          r_we;
   logic          r_busy;
   logic          r_done;

   logic          w_acc;
   logic          w_rd_done;
   logic          w_wr_done;
   logic          w_last;

   // A request is taken by the slave on any edge where stb is up and stall is low.
   assign w_acc     = r_stb & ~wb_stall_i;
   // Acks only count while an access is outstanding; a zero-wait ack rides on the accept edge.
   assign w_rd_done = ((r_state == RD_REQ) & w_acc & wb_ack_i) | ((r_state == RD_WAIT) & wb_ack_i);
   assign w_wr_done = ((r_state == WR_REQ) & w_acc & wb_ack_i) | ((r_state == WR_WAIT) & wb_ack_i);
   assign w_last    = (r_rem == LW'(1));

`ifdef WB_COPY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo;
   logic          r_err;
   logic          w_tmo;

   // Watchdog fires once the current request/wait pair has lasted TIMEOUT_CYCLES+1 cycles.
   assign w_tmo = r_busy & (r_tmo == TW'(TIMEOUT_CYCLES));
   assign err_o = r_err;
`else
   logic w_unused_tmo;

   assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
   assign err_o        = 1'b0;
`endif

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign wb_cyc_o  = r_cyc;
   assign wb_stb_o  = r_stb;
   assign wb_we_o   = r_we;
   assign wb_addr_o = r_addr;
   assign wb_data_o = r_wdat;
   assign wb_sel_o  = {(DW/8){r_stb}};

   // Copy sequencer: state and every bus/status output registered together; later ifs override the case.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_addr  <= '0;
         r_rem   <= '0;
         r_wdat  <= '0;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
         r_tmo   <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
         r_err  <= 1'b0;
         r_tmo  <= r_busy ? r_tmo + 1'b1 : '0;
`endif
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  if (len_i != '0) begin
                     r_src   <= src_i;
                     r_dst   <= dst_i;
                     r_rem   <= len_i;
                     r_addr  <= src_i;
                     r_we    <= 1'b0;
                     r_cyc   <= 1'b1;
                     r_stb   <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= RD_REQ;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            RD_REQ: begin
               if (w_acc) begin
                  r_stb   <= 1'b0;
                  r_state <= RD_WAIT;
               end
            end
            WR_REQ: begin
               if (w_acc) begin
                  r_stb   <= 1'b0;
                  r_state <= WR_WAIT;
               end
            end
            DONE:    r_state <= IDLE;
            default: ;
         endcase

         if (w_rd_done) begin
            r_wdat  <= wb_data_i;
            r_addr  <= r_dst;
            r_we    <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= WR_REQ;
`ifdef WB_COPY_TIMEOUT_EN
            r_tmo   <= '0;
`endif
         end

         if (w_wr_done) begin
            r_src <= r_src + 1'b1;
            r_dst <= r_dst + 1'b1;
            r_rem <= r_rem - 1'b1;
            if (w_last) begin
               r_cyc   <= 1'b0;
               r_stb   <= 1'b0;
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= DONE;
            end else begin
               r_addr  <= r_src + 1'b1;
               r_we    <= 1'b0;
               r_stb   <= 1'b1;
               r_state <= RD_REQ;
`ifdef WB_COPY_TIMEOUT_EN
               r_tmo   <= '0;
`endif
            end
         end

`ifdef WB_COPY_TIMEOUT_EN
         if (w_tmo) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= DONE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: a 2048-word memory slave with programmable stall / ack style,
// a reference model built from plain array copies and an expected-access queue,
// table-driven directed copies, hand sequences for start-while-busy and reset, then random copies.
`timescale 1ns/1ps
module tb_wb_copy_master;

   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int LW    = 12;
   localparam int TMO   = 16;
   localparam int DEPTH = 2048;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            start_i = 1'b0;
   logic [AW-1:0]   src_i = '0;
   logic [AW-1:0]   dst_i = '0;
   logic [LW-1:0]   len_i = '0;
   logic            busy_o, done_o, err_o;
   logic            wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0]   wb_addr_o;
   logic [DW-1:0]   wb_data_o;
   logic [DW/8-1:0] wb_sel_o;
   logic            wb_ack_i = 1'b0;
   logic            wb_stall_i = 1'b0;
   logic [DW-1:0]   wb_data_i = '0;

   always #5 clk = ~clk;

   wb_copy_master #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
      .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
      .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_data_i(wb_data_i)
   );

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
   } acc_t;

   typedef struct {
      int src; int dst; int len; int st; int zw; int lat;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] exp_mem [DEPTH];
   acc_t          exp_q[$];

   // slave configuration
   int stall_n = 0;
   int zw      = 0;
   int noack   = 0;

   // slave / monitor state
   int            scnt = 0;
   logic          pend = 1'b0;
   logic [DW-1:0] pdat = '0;
   logic [DW-1:0] s_rd;
   acc_t          s_e;
   logic          snap_we;
   logic [AW-1:0] snap_addr;
   logic [DW-1:0] snap_dat;
   int            done_cnt = 0;
   int            cyc_cnt = 0;
   int            since = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory slave: decides stall/ack mid-cycle from the stable DUT outputs.
   always @(negedge clk) begin
      wb_ack_i   = 1'b0;
      wb_stall_i = 1'b0;
      wb_data_i  = $urandom;
      if (done_o === 1'b1) done_cnt++;
      if (wb_cyc_o === 1'b1) cyc_cnt++;
      if (rst_i) begin
         pend = 1'b0;
         scnt = 0;
      end else begin
         if (pend) begin
            wb_ack_i  = 1'b1;
            wb_data_i = pdat;
            pend      = 1'b0;
            chk("single outstanding", {63'd0, wb_stb_o}, 64'd0);
         end
         if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
            if (scnt == 0) begin
               snap_we   = wb_we_o;
               snap_addr = wb_addr_o;
               snap_dat  = wb_data_o;
            end else begin
               chk("stall addr stable", {53'd0, wb_addr_o}, {53'd0, snap_addr});
               chk("stall we stable", {63'd0, wb_we_o}, {63'd0, snap_we});
               if (snap_we) chk("stall data stable", {32'd0, wb_data_o}, {32'd0, snap_dat});
            end
            if (scnt < stall_n) begin
               wb_stall_i = 1'b1;
               scnt++;
            end else begin
               scnt = 0;
               chk("sel all ones", {60'd0, wb_sel_o}, 64'hF);
               if (noack == 0) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected access", 64'd1, 64'd0);
                  end else begin
                     s_e = exp_q.pop_front();
                     chk("access we", {63'd0, wb_we_o}, {63'd0, s_e.we});
                     chk("access addr", {53'd0, wb_addr_o}, {53'd0, s_e.addr});
                     if (s_e.we) chk("write data", {32'd0, wb_data_o}, {32'd0, s_e.dat});
                  end
               end
               s_rd = '0;
               if (wb_we_o) begin
                  if (noack == 0) mem[wb_addr_o] = wb_data_o;
               end else begin
                  s_rd = mem[wb_addr_o];
               end
               if (noack == 0) begin
                  if (zw != 0) begin
                     wb_ack_i  = 1'b1;
                     wb_data_i = s_rd;
                  end else begin
                     pend = 1'b1;
                     pdat = s_rd;
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
      since++;
   endtask

   // Reference: ascending word-by-word copy on the model memory, recording the access order.
   task automatic model_copy(input int s, input int d, input int l);
      acc_t r, w;
      for (int i = 0; i < l; i++) begin
         r.we   = 1'b0;
         r.addr = AW'((s + i) % DEPTH);
         r.dat  = '0;
         w.we   = 1'b1;
         w.addr = AW'((d + i) % DEPTH);
         w.dat  = exp_mem[r.addr];
         exp_mem[w.addr] = w.dat;
         exp_q.push_back(r);
         exp_q.push_back(w);
      end
   endtask

   task automatic issue_start(input int s, input int d, input int l);
      src_i    = AW'(s);
      dst_i    = AW'(d);
      len_i    = LW'(l);
      start_i  = 1'b1;
      done_cnt = 0;
      cyc_cnt  = 0;
      since    = 0;
      step();
      start_i  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat, input logic exp_err);
      while (done_o !== 1'b1 && since < 5000) step();
      chk({name, " done seen"}, {63'd0, done_o}, 64'd1);
      chk({name, " latency"}, 64'(since), 64'(exp_lat));
      chk({name, " err"}, {63'd0, err_o}, {63'd0, exp_err});
      chk({name, " busy at done"}, {63'd0, busy_o}, 64'd0);
      chk({name, " cyc at done"}, {63'd0, wb_cyc_o}, 64'd0);
      step();
      chk({name, " done width"}, {63'd0, done_o}, 64'd0);
      chk({name, " done count"}, 64'(done_cnt), 64'd1);
   endtask

   task automatic check_mem(input string name);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
      chk({name, " memory"}, 64'(bad), 64'd0);
      chk({name, " pending accesses"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      int   s, d, l, st, z;

      tbl[0] = '{4,    300,  4, 0, 0, 17};   // basic copy
      tbl[1] = '{7,    9,    0, 0, 0, 1};    // empty copy
      tbl[2] = '{2046, 10,   3, 0, 0, 13};   // source wraps
      tbl[3] = '{100,  2045, 4, 3, 0, 41};   // dest wraps, 3 stall cycles per request
      tbl[4] = '{5,    6,    4, 0, 1, 9};    // overlapping, zero-wait slave
      tbl[5] = '{20,   18,   3, 1, 1, 13};   // overlapping backwards, stall + zero-wait

      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = $urandom;
         exp_mem[i] = mem[i];
      end
      mem[4] = 32'h11111111; mem[5] = 32'h22222222; mem[6] = 32'h33333333; mem[7] = 32'h44444444;
      mem[2046] = 32'hCAFEF00D; mem[2047] = 32'h0BADBEEF; mem[0] = 32'h12345678;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];

      // reset state
      repeat (3) step();
      chk("reset cyc", {63'd0, wb_cyc_o}, 64'd0);
      chk("reset stb", {63'd0, wb_stb_o}, 64'd0);
      chk("reset we", {63'd0, wb_we_o}, 64'd0);
      chk("reset addr", {53'd0, wb_addr_o}, 64'd0);
      chk("reset data", {32'd0, wb_data_o}, 64'd0);
      chk("reset sel", {60'd0, wb_sel_o}, 64'd0);
      chk("reset busy", {63'd0, busy_o}, 64'd0);
      chk("reset done", {63'd0, done_o}, 64'd0);
      chk("reset err", {63'd0, err_o}, 64'd0);
      rst_i = 1'b0;
      step();

      // directed table
      for (int i = 0; i < 6; i++) begin
         stall_n = tbl[i].st;
         zw      = tbl[i].zw;
         model_copy(tbl[i].src, tbl[i].dst, tbl[i].len);
         issue_start(tbl[i].src, tbl[i].dst, tbl[i].len);
         if (tbl[i].len != 0) chk($sformatf("vec%0d busy", i), {63'd0, busy_o}, 64'd1);
         wait_done($sformatf("vec%0d", i), tbl[i].lat, 1'b0);
         if (tbl[i].len == 0) chk("len0 no bus cycle", 64'(cyc_cnt), 64'd0);
         check_mem($sformatf("vec%0d", i));
      end
      chk("B300", {32'd0, mem[300]}, 64'h11111111);
      chk("B303", {32'd0, mem[303]}, 64'h44444444);
      chk("B10", {32'd0, mem[10]}, 64'hCAFEF00D);
      chk("B11", {32'd0, mem[11]}, 64'h0BADBEEF);
      chk("B12", {32'd0, mem[12]}, 64'h12345678);

      // start while busy is ignored
      stall_n = 0; zw = 0;
      model_copy(40, 500, 3);
      issue_start(40, 500, 3);
      repeat (3) step();
      chk("busy mid copy", {63'd0, busy_o}, 64'd1);
      src_i = '0; dst_i = '0; len_i = LW'(5); start_i = 1'b1;
      step();
      start_i = 1'b0;
      wait_done("restart ignored", 13, 1'b0);
      check_mem("restart ignored");

      // reset during the write wait of word 2 of 4
      model_copy(60, 700, 2);
      issue_start(60, 700, 4);
      repeat (7) step();
      chk("pre-reset in write wait", {61'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'b101);
      rst_i = 1'b1;
      step();
      chk("reset drops cyc", {63'd0, wb_cyc_o}, 64'd0);
      chk("reset drops stb", {63'd0, wb_stb_o}, 64'd0);
      chk("reset clears busy", {63'd0, busy_o}, 64'd0);
      step();
      rst_i = 1'b0;
      step();
      step();
      chk("no done after reset", 64'(done_cnt), 64'd0);
      check_mem("reset abort");
      model_copy(60, 700, 4);
      issue_start(60, 700, 4);
      wait_done("after reset", 17, 1'b0);
      check_mem("after reset");

`ifdef WB_COPY_TIMEOUT_EN
      noack = 1;
      issue_start(1, 2, 2);
      wait_done("timeout", TMO + 2, 1'b1);
      noack = 0;
      check_mem("timeout");
`endif

      // random copies against the model
      for (int n = 0; n < 10; n++) begin
         s  = $urandom_range(0, DEPTH - 1);
         d  = $urandom_range(0, DEPTH - 1);
         l  = $urandom_range(1, 6);
         st = $urandom_range(0, 2);
         z  = $urandom_range(0, 1);
         stall_n = st;
         zw      = z;
         model_copy(s, d, l);
         issue_start(s, d, l);
         wait_done($sformatf("rand%0d", n), 1 + l * ((z != 0) ? (2 * st + 2) : (2 * st + 4)), 1'b0);
         check_mem($sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
